// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative div_unit between two requesters, with a one-entry response buffer.
// Optional reuse of the last completed divide is enabled by defining DIV_ARB_REUSE_EN.
module div_arbiter #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 64
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        flush_i,
    input  logic [1:0]                  req_valid_i,
    output logic [1:0]                  req_ready_o,
    input  logic [1:0]                  req_kill_i,
    input  logic [1:0]                  req_int_32_i,
    input  logic [1:0]                  req_signed_i,
    input  logic [1:0]                  req_rem_i,
    input  logic [1:0][DATA_W-1:0]      req_dvnd_i,
    input  logic [1:0][DATA_W-1:0]      req_dvsr_i,
    input  logic [1:0][TAG_W-1:0]       req_tag_i,
    output logic                        resp_valid_o,
    input  logic                        resp_ready_i,
    output logic [DATA_W-1:0]           resp_data_o,
    output logic                        resp_id_o,
    output logic [TAG_W-1:0]            resp_tag_o,
    output logic                        div_request_o,
    output logic                        div_kill_o,
    output logic                        div_int_32_o,
    output logic                        div_signed_o,
    output logic [DATA_W-1:0]           div_dvnd_o,
    output logic [DATA_W-1:0]           div_dvsr_o,
    input  logic [DATA_W-1:0]           div_quo_i,
    input  logic [DATA_W-1:0]           div_rmd_i,
    input  logic                        div_done_tick_i
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t              state_q, state_d;
    logic                rr_ptr_q;
    logic                win;
    logic [1:0]          grant;
    logic                abort;
    logic                capture;
    logic                hit;

    logic                id_p0, rem_p0, int_32_p0, signed_p0;
    logic [TAG_W-1:0]    tag_p0;
    logic [DATA_W-1:0]   dvnd_p0, dvsr_p0;
    logic [DATA_W-1:0]   result_p1;

    always_comb begin
        state_d       = state_q;
        grant         = 2'b00;
        capture       = 1'b0;
        div_request_o = 1'b0;
        div_kill_o    = 1'b0;
        win           = req_valid_i[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
        abort         = req_kill_i[id_p0] | flush_i;
        case (state_q)
            IDLE: begin
                if (req_valid_i[win] && !req_kill_i[win] && !flush_i) begin
                    grant[win] = 1'b1;
                    state_d    = hit ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    div_request_o = 1'b1;
                    state_d       = BUSY;
                end
            end
            BUSY: begin
                // A kill racing done_tick simply drops the result; the divider is already idle.
                if (abort) begin
                    div_kill_o = ~div_done_tick_i;
                    state_d    = IDLE;
                end else if (div_done_tick_i) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (abort || resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o = grant;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant != 2'b00) rr_ptr_q <= ~win;
        end
    end

`ifdef DIV_ARB_REUSE_EN
    logic                reuse_vld;
    logic                reuse_int_32, reuse_signed;
    logic [DATA_W-1:0]   reuse_dvnd, reuse_dvsr, reuse_quo, reuse_rmd;

    assign hit = reuse_vld && (reuse_dvnd == req_dvnd_i[win]) && (reuse_dvsr == req_dvsr_i[win]) &&
                 (reuse_int_32 == req_int_32_i[win]) && (reuse_signed == req_signed_i[win]);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            reuse_vld    <= 1'b0;
            reuse_int_32 <= 1'b0;
            reuse_signed <= 1'b0;
            reuse_dvnd   <= '0;
            reuse_dvsr   <= '0;
            reuse_quo    <= '0;
            reuse_rmd    <= '0;
        end else if (flush_i) begin
            reuse_vld <= 1'b0;
        end else if (capture) begin
            reuse_vld    <= 1'b1;
            reuse_int_32 <= int_32_p0;
            reuse_signed <= signed_p0;
            reuse_dvnd   <= dvnd_p0;
            reuse_dvsr   <= dvsr_p0;
            reuse_quo    <= div_quo_i;
            reuse_rmd    <= div_rmd_i;
        end
    end
`else
    assign hit = 1'b0;
`endif

    // Stage p0: request fields latched at grant, held until the op leaves the arbiter
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            id_p0     <= 1'b0;
            rem_p0    <= 1'b0;
            int_32_p0 <= 1'b0;
            signed_p0 <= 1'b0;
            tag_p0    <= '0;
            dvnd_p0   <= '0;
            dvsr_p0   <= '0;
        end else if (grant != 2'b00) begin
            id_p0     <= win;
            rem_p0    <= req_rem_i[win];
            int_32_p0 <= req_int_32_i[win];
            signed_p0 <= req_signed_i[win];
            tag_p0    <= req_tag_i[win];
            dvnd_p0   <= req_dvnd_i[win];
            dvsr_p0   <= req_dvsr_i[win];
        end
    end

    // Stage p1: selected result held in the response buffer
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            result_p1 <= '0;
        end else if (capture) begin
            result_p1 <= rem_p0 ? div_rmd_i : div_quo_i;
`ifdef DIV_ARB_REUSE_EN
        end else if (grant != 2'b00 && hit) begin
            result_p1 <= req_rem_i[win] ? reuse_rmd : reuse_quo;
`endif
        end
    end

    assign resp_valid_o = (state_q == RESP);
    assign resp_data_o  = result_p1;
    assign resp_id_o    = id_p0;
    assign resp_tag_o   = tag_p0;
    assign div_int_32_o = int_32_p0;
    assign div_signed_o = signed_p0;
    assign div_dvnd_o   = dvnd_p0;
    assign div_dvsr_o   = dvsr_p0;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: behavioural divider, transaction scoreboard and directed scenarios.
module tb_div_arbiter;
    localparam int TAG_W = 5;

    logic clk = 1'b0, rstn = 1'b0, flush = 1'b0;
    logic [1:0] req_valid = '0, req_kill = '0, req_int_32 = '0, req_signed = '0, req_rem = '0;
    logic [1:0][63:0] req_dvnd = '0, req_dvsr = '0;
    logic [1:0][TAG_W-1:0] req_tag = '0;
    logic resp_ready = 1'b1;
    logic [1:0] req_ready;
    logic resp_valid, resp_id, div_request, div_kill, div_int_32, div_signed;
    logic [63:0] resp_data, div_dvnd, div_dvsr;
    logic [TAG_W-1:0] resp_tag;
    logic [63:0] div_quo = '0, div_rmd = '0;
    logic div_done = 1'b0;

    int n_tests = 0, n_fail = 0;
    int n_div_req = 0, n_div_kill = 0, n_grant = 0;
    int lat_force = 0;

    div_arbiter #(.TAG_W(TAG_W), .DATA_W(64)) dut (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_kill_i(req_kill),
        .req_int_32_i(req_int_32), .req_signed_i(req_signed), .req_rem_i(req_rem),
        .req_dvnd_i(req_dvnd), .req_dvsr_i(req_dvsr), .req_tag_i(req_tag),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
        .resp_id_o(resp_id), .resp_tag_o(resp_tag),
        .div_request_o(div_request), .div_kill_o(div_kill), .div_int_32_o(div_int_32),
        .div_signed_o(div_signed), .div_dvnd_o(div_dvnd), .div_dvsr_o(div_dvsr),
        .div_quo_i(div_quo), .div_rmd_i(div_rmd), .div_done_tick_i(div_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // RISC-V divide semantics, including divide-by-zero and signed overflow.
    function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                            input logic w, input logic s, input logic r);
        logic [63:0] q, m;
        logic [31:0] q32, m32;
        if (w) begin
            if (b[31:0] == 32'd0) begin q32 = '1; m32 = a[31:0]; end
            else if (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
                q32 = 32'h8000_0000; m32 = '0;
            end else if (s) begin
                q32 = $signed(a[31:0]) / $signed(b[31:0]);
                m32 = $signed(a[31:0]) % $signed(b[31:0]);
            end else begin
                q32 = a[31:0] / b[31:0];
                m32 = a[31:0] % b[31:0];
            end
            q = {{32{q32[31]}}, q32};
            m = {{32{m32[31]}}, m32};
        end else begin
            if (b == 64'd0) begin q = '1; m = a; end
            else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = 64'h8000_0000_0000_0000; m = '0;
            end else if (s) begin
                q = $signed(a) / $signed(b);
                m = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                m = a % b;
            end
        end
        return r ? m : q;
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd1;
            2: return 64'd7;
            3: return 64'd100;
            4: return '1;
            5: return 64'h8000_0000_0000_0000;
            6: return 64'h0000_0000_8000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Behavioural div_unit: operands are read at done time, as the real unit does.
    int fd_cnt = 0;
    bit fd_busy = 0;
    always @(posedge clk) begin
        #2;
        div_done = 1'b0;
        if (!rstn) fd_busy = 0;
        else if (fd_busy) begin
            fd_cnt--;
            if (fd_cnt == 0) begin
                div_done = 1'b1;
                div_quo  = ref_div(div_dvnd, div_dvsr, div_int_32, div_signed, 1'b0);
                div_rmd  = ref_div(div_dvnd, div_dvsr, div_int_32, div_signed, 1'b1);
                fd_busy  = 0;
            end
        end
        #1;
        if (div_kill) fd_busy = 0;
        if (div_request) begin
            fd_busy = 1;
            fd_cnt  = (lat_force > 0) ? lat_force : int'($urandom_range(1, 6));
        end
    end

    // Transaction-level scoreboard: one op outstanding, alternating pointer for fairness.
    bit outstanding = 0, m_was = 0, hold_pend = 0;
    logic rr_model = 1'b0, w;
    logic [1:0] exp_g;
    logic own_id;
    logic [TAG_W-1:0] own_tag, hold_tag;
    logic [63:0] own_data, hold_data;
    logic hold_id;
    int glog[$];

    always @(negedge clk) begin
        if (!rstn) begin
            outstanding = 0; rr_model = 1'b0; hold_pend = 0;
        end else begin
            m_was = outstanding;
            if (div_request) n_div_req++;
            if (div_kill) n_div_kill++;
            if (!m_was) chk("idle_resp_valid", resp_valid, 1'b0);
            if (hold_pend && m_was && resp_valid) begin
                chk("hold_data", resp_data, hold_data);
                chk("hold_tag", resp_tag, hold_tag);
                chk("hold_id", resp_id, hold_id);
            end
            hold_pend = 0;
            if (m_was) begin
                if (req_kill[own_id] || flush) outstanding = 0;
                else if (resp_valid) begin
                    if (resp_ready) begin
                        chk("resp_data", resp_data, own_data);
                        chk("resp_id", resp_id, own_id);
                        chk("resp_tag", resp_tag, own_tag);
                        outstanding = 0;
                    end else begin
                        hold_pend = 1;
                        hold_data = resp_data; hold_tag = resp_tag; hold_id = resp_id;
                    end
                end
                chk("ready_busy", req_ready, 2'b00);
            end else begin
                w = req_valid[rr_model] ? rr_model : ~rr_model;
                exp_g = (req_valid[w] && !req_kill[w] && !flush) ? (2'b01 << w) : 2'b00;
                chk("grant", req_ready, exp_g);
                if (exp_g != 2'b00) begin
                    own_id = w;
                    own_tag = req_tag[w];
                    own_data = ref_div(req_dvnd[w], req_dvsr[w], req_int_32[w], req_signed[w], req_rem[w]);
                    outstanding = 1;
                    rr_model = ~w;
                    n_grant++;
                    glog.push_back(int'(w));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_grant(input int id);
        bit ok = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            ok = req_ready[id];
            tick();
        end
        chk("grant_wait", ok, 1'b1);
    endtask

    task automatic wait_resp(output int lat);
        bit ok = 0;
        lat = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = resp_valid;
            if (!ok) begin lat++; tick(); end
        end
        chk("resp_wait", ok, 1'b1);
    endtask

    task automatic do_req(input int id, input logic [63:0] a, input logic [63:0] b, input logic wop,
                          input logic s, input logic r, input logic [TAG_W-1:0] tag,
                          input logic [63:0] exp, output int lat);
        resp_ready = 1'b1;
        req_dvnd[id] = a; req_dvsr[id] = b; req_int_32[id] = wop;
        req_signed[id] = s; req_rem[id] = r; req_tag[id] = tag;
        req_valid[id] = 1'b1;
        wait_grant(id);
        req_valid[id] = 1'b0;
        wait_resp(lat);
        chk("dir_data", resp_data, exp);
        chk("dir_id", resp_id, id[0]);
        chk("dir_tag", resp_tag, tag);
        tick();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req_valid = '0; req_kill = '0; flush = 1'b0;
        tick(); tick();
        rstn = 1'b1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, n0, saw, g0, q0;
        do_reset();
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_div_req", div_request, 1'b0);
        chk("rst_div_kill", div_kill, 1'b0);
        chk("rst_dvnd", div_dvnd, 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_resp_tag", resp_tag, '0);
        tick();
        rstn = 1'b1;
        tick();

        n0 = n_div_req;
        do_req(0, 64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 5'h0b, 64'd14, lat);
        chk("div_pulses", n_div_req - n0, 1);
        do_req(1, 64'hFFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b0, 5'h15, 64'hFFFF_FFFF_FFFF_FFFD, lat);
        do_req(0, 64'h1234_5678_9ABC, 64'd0, 1'b0, 1'b0, 1'b1, 5'h03, 64'h1234_5678_9ABC, lat);

`ifdef DIV_ARB_REUSE_EN
        do_req(0, 64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 5'h06, 64'd14, lat);
        n0 = n_div_req;
        do_req(0, 64'd100, 64'd7, 1'b0, 1'b1, 1'b1, 5'h07, 64'd2, lat);
        chk("reuse_no_div", n_div_req - n0, 0);
        chk("reuse_lat", lat, 0);
`endif

        // Kill the owner while the divider is busy.
        lat_force = 6;
        n0 = n_div_kill;
        req_dvnd[0] = 64'd1000; req_dvsr[0] = 64'd3; req_int_32[0] = 0; req_signed[0] = 0;
        req_rem[0] = 0; req_tag[0] = 5'h11; req_valid[0] = 1'b1;
        wait_grant(0);
        req_valid[0] = 1'b0;
        tick(); tick();
        req_kill[0] = 1'b1;
        tick();
        req_kill[0] = 1'b0;
        saw = 0;
        for (int k = 0; k < 10; k++) begin @(negedge clk); if (resp_valid) saw = 1; tick(); end
        chk("kill_pulse", n_div_kill - n0, 1);
        chk("kill_no_resp", saw, 0);
        do_req(0, 64'd100, 64'd9, 1'b0, 1'b1, 1'b1, 5'h12, 64'd1, lat);

        // Flush while requester 1 owns the divider.
        n0 = n_div_kill;
        req_dvnd[1] = 64'd77; req_dvsr[1] = 64'd5; req_rem[1] = 0; req_valid[1] = 1'b1;
        wait_grant(1);
        req_valid[1] = 1'b0;
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        saw = 0;
        for (int k = 0; k < 10; k++) begin @(negedge clk); if (resp_valid) saw = 1; tick(); end
        chk("flush_pulse", n_div_kill - n0, 1);
        chk("flush_no_resp", saw, 0);
        lat_force = 0;

        // Backpressure: response held while the other requester waits.
        resp_ready = 1'b0;
        req_dvnd[0] = 64'd50; req_dvsr[0] = 64'd6; req_int_32[0] = 0; req_signed[0] = 1;
        req_rem[0] = 1; req_tag[0] = 5'h1e; req_valid[0] = 1'b1;
        wait_grant(0);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1; req_dvnd[1] = 64'd9; req_dvsr[1] = 64'd4; req_rem[1] = 0;
        wait_resp(lat);
        tick();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_ready", req_ready, 2'b00);
            chk("bp_valid", resp_valid, 1'b1);
            chk("bp_data", resp_data, 64'd2);
            tick();
        end
        resp_ready = 1'b1;
        wait_grant(1);
        req_valid[1] = 1'b0;
        wait_resp(lat);
        chk("bp_next_data", resp_data, 64'd2);
        tick();

        // Fair alternation from reset with both requesters always valid.
        do_reset();
        glog.delete();
        req_valid = 2'b11;
        for (int k = 0; k < 300 && glog.size() < 4; k++) tick();
        req_valid = 2'b00;
        chk("rr_count", (glog.size() >= 4), 1'b1);
        if (glog.size() >= 4) begin
            chk("rr_g0", glog[0], 0);
            chk("rr_g1", glog[1], 1);
            chk("rr_g2", glog[2], 0);
            chk("rr_g3", glog[3], 1);
        end
        for (int k = 0; k < 30; k++) tick();

        // Randomized traffic.
        g0 = n_grant; q0 = n_div_req;
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < 2; i++) begin
                req_valid[i] = 1'($urandom_range(0, 1));
                req_dvnd[i] = pick(); req_dvsr[i] = pick();
                req_int_32[i] = 1'($urandom_range(0, 1));
                req_signed[i] = 1'($urandom_range(0, 1));
                req_rem[i] = 1'($urandom_range(0, 1));
                req_tag[i] = TAG_W'($urandom);
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = 2'b00;
        resp_ready = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        chk("drain", outstanding, 1'b0);
        chk("rand_grants", (n_grant - g0 > 20), 1'b1);
`ifndef DIV_ARB_REUSE_EN
        chk("div_per_grant", n_div_req - q0, n_grant - g0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
